// File: rtl/cim_bank_write_ctrl_pkg.sv
// Shared types for the CIM bank write controller: FSM state encoding and the request record.
// The request record is sized from the package default geometry.
package cim_pkg;

  localparam int CIM_DATA_W    = 24;
  localparam int CIM_ADDR_W    = 8;
  localparam int CIM_NUM_BANKS = 4;
  localparam int CIM_BANK_W    = $clog2(CIM_NUM_BANKS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    ERR
  } cim_state_t;

  typedef struct packed {
    logic [CIM_BANK_W-1:0] bank;
    logic [CIM_ADDR_W-1:0] addr;
    logic [CIM_DATA_W-1:0] data;
  } cim_wr_req_t;

endpackage

// File: rtl/cim_bank_write_ctrl_if.sv
// Write-request channel between the macro command decoder (master) and the bank write
// controller (slave).
interface cim_bank_write_ctrl_if #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 4
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  // Handshake: the master holds req_valid and req_bank/addr/data stable until a rising edge
  // with req_valid && req_ready, which is the single transfer edge; req_ready never depends
  // on req_valid.
  logic              req_valid;
  logic              req_ready;
  logic [BANK_W-1:0] req_bank;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  modport master (output req_valid, req_bank, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_bank, req_addr, req_data, output req_ready);

endinterface

// File: rtl/cim_bank_write_ctrl_skid.sv
// One-entry request buffer with bypass: an empty buffer passes a request straight through
// when the consumer takes it, otherwise stores it; in_ready is simply "not full".
module cim_wr_skid
  import cim_pkg::*;
#(
  parameter type T = cim_wr_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic full
);

  logic full_q, full_d;
  T     buf_q, buf_d;

  assign in_ready  = !full_q;
  assign full      = full_q;
  assign out_valid = full_q || in_valid;
  assign out_data  = full_q ? buf_q : in_data;

  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    if (full_q) begin
      if (out_ready) full_d = 1'b0;
    end else if (in_valid && !out_ready) begin
      full_d = 1'b1;
      buf_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
    end
  end

endmodule

// File: rtl/cim_bank_write_ctrl.sv
// CIM multi-bank write controller: sequences each write as SETUP -> PULSE -> HOLD and drives
// only the target bank's address lane and enable. Define CIM_WR_SKID_EN for a one-entry skid.
module cim_bank_write_ctrl
  import cim_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int PULSE_CYC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  cim_bank_write_ctrl_if.slave        req,
  output logic [DATA_W-1:0]           D1,
  output logic [NUM_BANKS*ADDR_W-1:0] WA,
  output logic [NUM_BANKS-1:0]        wr_en,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output cim_state_t                  state_o
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int CNT_W  = (PULSE_CYC < 1) ? 1 : $clog2(PULSE_CYC + 1);

  if (PULSE_CYC < 1) begin : g_bad_pulse
    $error("PULSE_CYC must be at least 1");
  end
  if (NUM_BANKS < 2) begin : g_bad_banks
    $error("NUM_BANKS must be at least 2");
  end

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  cim_state_t                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  req_t                        cur_q, cur_d;
  logic [DATA_W-1:0]           d1_q, d1_d;
  logic [NUM_BANKS*ADDR_W-1:0] wa_q, wa_d;
  logic [NUM_BANKS-1:0]        wr_en_q, wr_en_d;
  logic                        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                        drive_d;

  req_t src_data;
  logic src_valid, take, skid_full, src_oob;

`ifdef CIM_WR_SKID_EN
  req_t in_data;
  assign in_data = {req.req_bank, req.req_addr, req.req_data};

  cim_wr_skid #(.T(req_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (req.req_valid),
    .in_ready  (req.req_ready),
    .in_data   (in_data),
    .out_valid (src_valid),
    .out_ready (take),
    .out_data  (src_data),
    .full      (skid_full)
  );
`else
  assign skid_full     = 1'b0;
  assign src_valid     = req.req_valid;
  assign src_data      = {req.req_bank, req.req_addr, req.req_data};
  assign req.req_ready = (state_q == IDLE);
`endif

  // A buffered request may start straight out of HOLD/ERR; a fresh one needs IDLE.
  assign take    = (state_q == IDLE) || (skid_full && (state_q == HOLD || state_q == ERR));
  assign src_oob = ({1'b0, src_data.bank} >= (BANK_W + 1)'(NUM_BANKS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    unique case (state_q)
      IDLE, HOLD, ERR: begin
        state_d = IDLE;
        if (src_valid && take) begin
          cur_d   = src_data;
          state_d = src_oob ? ERR : SETUP;
        end
      end
      SETUP: begin
        state_d = PULSE;
        cnt_d   = CNT_W'(1);
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYC)) state_d = HOLD;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    drive_d = state_d inside {SETUP, PULSE, HOLD};
    d1_d    = drive_d ? cur_d.data : '0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == HOLD);
    err_d   = (state_d == ERR);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_lane
    logic sel;
    assign sel = (cur_d.bank == BANK_W'(b));
    assign wa_d[b*ADDR_W +: ADDR_W] = (drive_d && sel) ? cur_d.addr : '0;
    assign wr_en_d[b] = (state_d == PULSE) && sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      d1_q    <= '0;
      wa_q    <= '0;
      wr_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      d1_q    <= d1_d;
      wa_q    <= wa_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign D1      = d1_q;
  assign WA      = wa_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cim_bank_write_ctrl.sv
// Self-checking bench for cim_bank_write_ctrl: table vectors, timed corner sequences and a
// scoreboard that matches each done pulse against the request that caused it.
module tb_cim_bank_write_ctrl;
  import cim_pkg::*;

  localparam int DATA_W    = 24;
  localparam int ADDR_W    = 8;
  localparam int NUM_BANKS = 4;
  localparam int PULSE_CYC = 2;
  localparam int BANK_W    = 2;
  localparam int W         = BANK_W + ADDR_W + DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT, 4 banks
  cim_bank_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS)) rq ();
  logic [DATA_W-1:0]           d1;
  logic [NUM_BANKS*ADDR_W-1:0] wa;
  logic [NUM_BANKS-1:0]        wr_en;
  logic                        busy, done, err;
  cim_state_t                  state;

  cim_bank_write_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS),
                        .PULSE_CYC(PULSE_CYC)) dut (
    .clk(clk), .rst(rst), .req(rq), .D1(d1), .WA(wa), .wr_en(wr_en),
    .busy(busy), .done(done), .err(err), .state_o(state)
  );

  // second DUT, 3 banks, for the out-of-range bank case
  cim_bank_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(3)) rq3 ();
  logic [DATA_W-1:0] d1_3;
  logic [3*ADDR_W-1:0] wa3;
  logic [2:0]        wr_en3;
  logic              busy3, done3, err3;
  cim_state_t        state3;

  cim_bank_write_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(3),
                        .PULSE_CYC(PULSE_CYC)) dut3 (
    .clk(clk), .rst(rst), .req(rq3), .D1(d1_3), .WA(wa3), .wr_en(wr_en3),
    .busy(busy3), .done(done3), .err(err3), .state_o(state3)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    rq.req_valid = 1'b1;
    rq.req_bank  = b;
    rq.req_addr  = a;
    rq.req_data  = d;
  endtask

  task automatic idle_req();
    rq.req_valid = 1'b0;
    rq.req_bank  = BANK_W'($urandom);
    rq.req_addr  = ADDR_W'($urandom);
    rq.req_data  = DATA_W'($urandom);
  endtask

  task automatic wait_done(output int k);
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [BANK_W-1:0]           bank;
    logic [ADDR_W-1:0]           addr;
    logic [DATA_W-1:0]           data;
    logic [NUM_BANKS-1:0]        exp_wr_en;
    logic [NUM_BANKS*ADDR_W-1:0] exp_wa;
  } vec_t;

  // Called at a negedge with the DUT idle; walks one full write and checks each phase.
  task automatic run_vec(input vec_t v);
    drive_req(v.bank, v.addr, v.data);
    check("ready_idle", rq.req_ready, 1);
    exp_q.push_back({v.bank, v.addr, v.data});
    @(negedge clk);
    idle_req();
    check("setup_wr_en", wr_en, 0);
    check("setup_d1", d1, v.data);
    check("setup_wa", wa, v.exp_wa);
    check("setup_busy", busy, 1);
    for (int k = 0; k < PULSE_CYC; k++) begin
      @(negedge clk);
      check("pulse_wr_en", wr_en, v.exp_wr_en);
      check("pulse_wa", wa, v.exp_wa);
      check("pulse_done", done, 0);
    end
    @(negedge clk);
    check("hold_done", done, 1);
    check("hold_wr_en", wr_en, 0);
    check("hold_d1", d1, v.data);
    check("hold_busy", busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_d1", d1, 0);
    check("idle_wa", wa, 0);
    check("idle_ready", rq.req_ready, 1);
  endtask

  // scoreboard monitor, sampled 1 time unit after each rising edge
  logic [W-1:0]                front;
  logic [BANK_W-1:0]           fb;
  logic [NUM_BANKS*ADDR_W-1:0] lane_mask;
  int                          pulse_cnt;
  logic [NUM_BANKS-1:0]        pulse_seen;

  initial begin
    pulse_cnt  = 0;
    pulse_seen = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pulse_cnt  = 0;
        pulse_seen = '0;
      end else begin
        check("wr_en_onehot0", $onehot0(wr_en), 1);
        if (wr_en != '0) begin
          pulse_cnt++;
          pulse_seen |= wr_en;
        end
        if (exp_q.size() == 0) begin
          check("no_req_outputs", {wr_en, wa, d1, done, err}, 0);
        end else begin
          front     = exp_q[0];
          fb        = front[W-1 -: BANK_W];
          lane_mask = (NUM_BANKS*ADDR_W)'({ADDR_W{1'b1}}) << (fb * ADDR_W);
          check("unsel_lanes_zero", wa & ~lane_mask, 0);
          if (done) begin
            check("sb_addr", wa[fb*ADDR_W +: ADDR_W], front[DATA_W +: ADDR_W]);
            check("sb_data", d1, front[DATA_W-1:0]);
            check("sb_pulse_len", pulse_cnt, PULSE_CYC);
            check("sb_pulse_bank", pulse_seen, 1 << fb);
            void'(exp_q.pop_front());
            pulse_cnt  = 0;
            pulse_seen = '0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  vec_t vecs[4];
  int   k;

  initial begin
    vecs[0] = '{2'd0, 8'hA5, 24'hABCDEF, 4'b0001, 32'h0000_00A5};
    vecs[1] = '{2'd3, 8'h5A, 24'h123456, 4'b1000, 32'h5A00_0000};
    vecs[2] = '{2'd1, 8'h3C, 24'hFFFFFF, 4'b0010, 32'h0000_3C00};
    vecs[3] = '{2'd2, 8'hFF, 24'h000001, 4'b0100, 32'h00FF_0000};

    // reset with a request pending: nothing accepted, everything quiet
    rst = 1'b1;
    drive_req(2'd0, 8'hA5, 24'hABCDEF);
    rq3.req_valid = 1'b0;
    rq3.req_bank  = '0;
    rq3.req_addr  = '0;
    rq3.req_data  = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", rq.req_ready, 1);
      check("rst_outputs", {wr_en, wa, d1, busy, done, err}, 0);
      check("rst_state", state, IDLE);
    end
    idle_req();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, state}, {1'b0, IDLE});

    // table vectors
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // random writes
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.bank      = BANK_W'($urandom_range(0, NUM_BANKS - 1));
      v.addr      = ADDR_W'($urandom_range(0, 255));
      v.data      = DATA_W'($urandom);
      v.exp_wr_en = NUM_BANKS'(1) << v.bank;
      v.exp_wa    = (NUM_BANKS*ADDR_W)'(v.addr) << (v.bank * ADDR_W);
      run_vec(v);
    end

    // reset in the first PULSE cycle: enable drops, request lost, no done
    drive_req(2'd2, 8'h77, 24'h0F0F0F);
    exp_q.push_back({2'd2, 8'h77, 24'h0F0F0F});
    @(negedge clk);
    idle_req();
    @(negedge clk);
    check("rstp_pulse_wr_en", wr_en, 4'b0100);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rstp_wr_en", wr_en, 0);
    check("rstp_done", done, 0);
    check("rstp_busy", busy, 0);
    check("rstp_ready", rq.req_ready, 1);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rstp_no_late_done", {done, wr_en}, 0);
    end

    // out-of-range bank on the 3-bank instance
    rq3.req_valid = 1'b1;
    rq3.req_bank  = 2'd3;
    rq3.req_addr  = 8'h11;
    rq3.req_data  = 24'h222222;
    check("oob_ready", rq3.req_ready, 1);
    @(negedge clk);
    rq3.req_valid = 1'b0;
    check("oob_err", err3, 1);
    check("oob_state", state3, ERR);
    check("oob_quiet", {wr_en3, wa3, d1_3, done3}, 0);
    check("oob_busy", busy3, 1);
    @(negedge clk);
    check("oob_err_1cyc", err3, 0);
    check("oob_back_idle", {busy3, done3, state3}, {2'b00, IDLE});
    check("oob_ready_again", rq3.req_ready, 1);
    // valid top bank on the 3-bank instance
    rq3.req_valid = 1'b1;
    rq3.req_bank  = 2'd2;
    rq3.req_addr  = 8'h9C;
    rq3.req_data  = 24'h345678;
    @(negedge clk);
    rq3.req_valid = 1'b0;
    @(negedge clk);
    check("b3_wr_en", wr_en3, 3'b100);
    check("b3_wa", wa3, 24'h9C_0000);
    @(negedge clk);
    @(negedge clk);
    check("b3_done", {done3, err3}, 2'b10);
    @(negedge clk);
    check("b3_idle", busy3, 0);

    // back-to-back requests: bank 1, then bank 2 offered while busy
    drive_req(2'd1, 8'h12, 24'hAAAA01);
    check("b2b_ready_a", rq.req_ready, 1);
    exp_q.push_back({2'd1, 8'h12, 24'hAAAA01});
    @(negedge clk);
    idle_req();
    @(negedge clk);
    drive_req(2'd2, 8'h34, 24'hBBBB02);
`ifdef CIM_WR_SKID_EN
    check("skid_ready_busy", rq.req_ready, 1);
    exp_q.push_back({2'd2, 8'h34, 24'hBBBB02});
    @(negedge clk);
    idle_req();
    check("skid_full_ready", rq.req_ready, 0);
    @(negedge clk);
    check("b2b_first_done", done, 1);
    @(negedge clk);
    check("b2b_setup_state", state, SETUP);
    check("b2b_setup_d1", d1, 24'hBBBB02);
    check("b2b_setup_done", done, 0);
    wait_done(k);
    check("b2b_done_gap", k + 1, 4);
`else
    check("noskid_ready_busy", rq.req_ready, 0);
    k = 0;
    while (!rq.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("noskid_ready_wait", k, 3);
    exp_q.push_back({2'd2, 8'h34, 24'hBBBB02});
    @(negedge clk);
    idle_req();
    check("noskid_setup_state", state, SETUP);
    wait_done(k);
    check("noskid_done_lat", k, PULSE_CYC + 1);
`endif
    @(negedge clk);
    check("b2b_end_idle", busy, 0);
    @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
